// File: rtl/xlr8_text_fetch.sv
// xlr8_text_fetch: text-mode read pipeline, video counters -> char/attr RAM -> font ROM -> RGB.
// Optional macro TEXT_BLINK_EN: vsync-driven blink counter, attr[7] marks blinking cells.
module xlr8_text_fetch #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  row_offset,
    output logic [12:0] ram_address,
    output logic        ram_re,
    input  logic [7:0]  ram_char_data,
    input  logic [7:0]  ram_attr_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [23:0] rgb,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam logic [7:0] ROWS_B = 8'(ROWS);
    localparam logic [5:0] ROWS_S = 6'(ROWS);

    function automatic logic [23:0] cga(input logic [3:0] idx);
        case (idx)
            4'h0: cga = 24'h000000;
            4'h1: cga = 24'h0000AA;
            4'h2: cga = 24'h00AA00;
            4'h3: cga = 24'h00AAAA;
            4'h4: cga = 24'hAA0000;
            4'h5: cga = 24'hAA00AA;
            4'h6: cga = 24'hAA5500;
            4'h7: cga = 24'hAAAAAA;
            4'h8: cga = 24'h555555;
            4'h9: cga = 24'h5555FF;
            4'hA: cga = 24'h55FF55;
            4'hB: cga = 24'h55FFFF;
            4'hC: cga = 24'hFF5555;
            4'hD: cga = 24'hFF55FF;
            4'hE: cga = 24'hFFFF55;
            default: cga = 24'hFFFFFF;
        endcase
    endfunction

    logic        fetch;
    logic [5:0]  row_sum;
    logic [4:0]  row_eff;
    logic [12:0] ram_addr_d;
    logic [12:0] ram_addr_q;
    logic        ram_re_q;
    logic        fetch2_q;
    logic [2:0]  cx1_q, cx2_q, cx3_q, cx4_q;
    logic [3:0]  cy1_q, cy2_q;
    logic [4:0]  de_sr_q, hs_sr_q, vs_sr_q;
    logic [7:0]  attr_q, attr4_q;
    logic [11:0] font_addr_q;
    logic [3:0]  fg, bg;
    logic        pix;
    logic [23:0] rgb_d, rgb_q;

    always_comb begin
        fetch   = de_in && (cx[2:0] == 3'd0) && (cy < 10'd480) && (cx < 10'd640);
        row_sum = {1'b0, cy[8:4]} + ((row_offset < ROWS_B) ? row_offset[5:0] : 6'd0);
        // Both operands are below ROWS, so a single conditional subtract wraps the scroll.
        row_eff    = (row_sum >= ROWS_S) ? 5'(row_sum - ROWS_S) : row_sum[4:0];
        ram_addr_d = 13'(row_eff) * 13'(COLS) + 13'(cx[9:3]);
    end

`ifdef TEXT_BLINK_EN
    logic [4:0] blink_q;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            blink_q <= '0;
        end else if (vsync_in && !vs_sr_q[0]) begin
            blink_q <= blink_q + 5'd1;
        end
    end
`endif

    always_comb begin
        fg = attr4_q[3:0];
`ifdef TEXT_BLINK_EN
        bg = {1'b0, attr4_q[6:4]};
        if (attr4_q[7] && blink_q[4]) fg = bg;
`else
        bg = attr4_q[7:4];
`endif
        pix   = font_data[3'd7 - cx4_q];
        rgb_d = de_sr_q[3] ? cga(pix ? fg : bg) : 24'h0;
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_re_q    <= 1'b0;
            fetch2_q    <= 1'b0;
            cx1_q       <= '0;
            cx2_q       <= '0;
            cx3_q       <= '0;
            cx4_q       <= '0;
            cy1_q       <= '0;
            cy2_q       <= '0;
            de_sr_q     <= '0;
            hs_sr_q     <= '0;
            vs_sr_q     <= '0;
            attr_q      <= '0;
            attr4_q     <= '0;
            font_addr_q <= '0;
            rgb_q       <= '0;
        end else begin
            if (fetch) ram_addr_q <= ram_addr_d;
            ram_re_q <= fetch;
            fetch2_q <= ram_re_q;
            cx1_q    <= cx[2:0];
            cx2_q    <= cx1_q;
            cx3_q    <= cx2_q;
            cx4_q    <= cx3_q;
            cy1_q    <= cy[3:0];
            cy2_q    <= cy1_q;
            de_sr_q  <= {de_sr_q[3:0], de_in};
            hs_sr_q  <= {hs_sr_q[3:0], hsync_in};
            vs_sr_q  <= {vs_sr_q[3:0], vsync_in};
            if (fetch2_q) begin
                attr_q      <= ram_attr_data;
                font_addr_q <= {ram_char_data, cy2_q};
            end
            // Extra attr stage keeps the colour aligned with font_data across cell boundaries.
            attr4_q <= attr_q;
            rgb_q   <= rgb_d;
        end
    end

    assign ram_address = ram_addr_q;
    assign ram_re      = ram_re_q;
    assign font_addr   = font_addr_q;
    assign rgb         = rgb_q;
    assign de_out      = de_sr_q[4];
    assign hsync_out   = hs_sr_q[4];
    assign vsync_out   = vs_sr_q[4];
endmodule

// File: tb/tb_xlr8_text_fetch.sv
// Bench for xlr8_text_fetch: directed steps plus random scanlines against a cell-level reference model.
module tb_xlr8_text_fetch;
    logic        clk_pixel = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  cx = '0, cy = '0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [7:0]  row_offset = '0;
    logic [12:0] ram_address;
    logic        ram_re;
    logic [7:0]  ram_char_data, ram_attr_data, font_data;
    logic [11:0] font_addr;
    logic [23:0] rgb;
    logic        de_out, hsync_out, vsync_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_pixel = ~clk_pixel;

    xlr8_text_fetch #(.COLS(80), .ROWS(30)) dut (
        .clk_pixel(clk_pixel), .rst(rst), .cx(cx), .cy(cy), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .row_offset(row_offset),
        .ram_address(ram_address), .ram_re(ram_re), .ram_char_data(ram_char_data),
        .ram_attr_data(ram_attr_data), .font_addr(font_addr), .font_data(font_data),
        .rgb(rgb), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    logic [7:0] cmem [0:2399];
    logic [7:0] amem [0:2399];
    logic [7:0] font [0:4095];

    always @(posedge clk_pixel) begin
        if (ram_re) begin
            ram_char_data <= cmem[ram_address];
            ram_attr_data <= amem[ram_address];
        end
        font_data <= font[font_addr];
    end

    logic [23:0] pal [16] = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                              24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                              24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                              24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q[$];
    int   m_addr, m_char, m_attr, m_row;
`ifdef TEXT_BLINK_EN
    int   m_blink;
    bit   m_prev_vs;
`endif
    logic [23:0] cap [13];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        z = '0;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(z);
        m_addr = 0; m_char = 0; m_attr = 0; m_row = 0;
`ifdef TEXT_BLINK_EN
        m_blink = 0; m_prev_vs = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        @(posedge clk_pixel); #1;
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_de", 32'(de_out), 0);
        chk("rst_hs", 32'(hsync_out), 0);
        chk("rst_vs", 32'(vsync_out), 0);
        chk("rst_re", 32'(ram_re), 0);
        chk("rst_addr", 32'(ram_address), 0);
        chk("rst_font", 32'(font_addr), 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One pixel: drive inputs, advance the model, clock, then compare.
    task automatic step(input int x, input int y, input bit d, input bit h, input bit v, input int off);
        exp_t e;
        bit   f;
        int   row, fg, bg, bitv;
        cx = 10'(x); cy = 10'(y); de_in = d; hsync_in = h; vsync_in = v; row_offset = 8'(off);
        f = d && ((x % 8) == 0) && (y < 480) && (x < 640);
        if (f) begin
            row = (y / 16) + ((off < 30) ? off : 0);
            if (row >= 30) row -= 30;
            m_addr = row * 80 + x / 8;
            m_char = int'(cmem[m_addr]);
            m_attr = int'(amem[m_addr]);
            m_row  = y % 16;
        end
        bitv = (int'(font[m_char * 16 + m_row]) >> (7 - (x % 8))) & 1;
        fg = m_attr & 15;
`ifdef TEXT_BLINK_EN
        if (v && !m_prev_vs) m_blink = (m_blink + 1) % 32;
        m_prev_vs = v;
        bg = (m_attr >> 4) & 7;
        if (((m_attr >> 7) & 1) == 1 && (m_blink & 16) != 0) fg = bg;
`else
        bg = (m_attr >> 4) & 15;
`endif
        e.rgb = d ? pal[bitv != 0 ? fg : bg] : 24'h0;
        e.de = d; e.hs = h; e.vs = v;
        q.push_back(e);
        @(posedge clk_pixel); #1;
        chk("ram_re", 32'(ram_re), 32'(f));
        chk("ram_address", 32'(ram_address), 32'(m_addr));
        e = q.pop_front();
        chk("rgb", 32'(rgb), 32'(e.rgb));
        chk("de_out", 32'(de_out), 32'(e.de));
        chk("hsync_out", 32'(hsync_out), 32'(e.hs));
        chk("vsync_out", 32'(vsync_out), 32'(e.vs));
    endtask

    task automatic run_cell(input int x0);
        for (int i = 0; i < 13; i++) begin
            step(x0 + i, 0, i < 8, 0, 0, 0);
            cap[i] = rgb;
        end
    endtask

    initial begin
        for (int i = 0; i < 2400; i++) begin
            cmem[i] = 8'($urandom);
            amem[i] = 8'($urandom);
        end
        for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
        cmem[0] = 8'h41; amem[0] = 8'h1F;
        cmem[1] = 8'h41; amem[1] = 8'h9F;
        font[12'h410] = 8'h81;

        do_reset();
        step(0, 0, 1, 0, 0, 0);
        chk("t1_re", 32'(ram_re), 1);
        chk("t1_addr", 32'(ram_address), 0);
        step(632, 479, 1, 0, 0, 0);
        chk("t2_addr_2399", 32'(ram_address), 2399);
        step(632, 400, 1, 0, 0, 5);
        chk("t2_addr_wrap", 32'(ram_address), 79);
        step(632, 479, 1, 0, 0, 200);
        chk("t5_off200", 32'(ram_address), 2399);

        do_reset();
        run_cell(0);
        chk("t3_px0", 32'(cap[4]), 32'h FFFFFF);
        for (int i = 1; i < 7; i++) chk("t3_bg", 32'(cap[4 + i]), 32'h0000AA);
        chk("t3_px7", 32'(cap[11]), 32'h FFFFFF);

        for (int x = 0; x < 40; x++) begin
            step(x, 16, 0, x >= 8 && x < 12, 0, 0);
            chk("t4_re", 32'(ram_re), 0);
            chk("t4_rgb", 32'(rgb), 0);
            if (x == 11) chk("t4_hs_pre", 32'(hsync_out), 0);
            if (x == 12) chk("t4_hs_del", 32'(hsync_out), 1);
        end

        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(700, 500, 0, 0, 1, 0);
            step(700, 500, 0, 0, 0, 0);
        end
        for (int k = 0; k < 6; k++) step(700, 500, 0, 0, 0, 0);
        run_cell(8);
`ifdef TEXT_BLINK_EN
        chk("t6_fg_blink", 32'(cap[4]), 32'h0000AA);
        chk("t6_bg", 32'(cap[5]), 32'h0000AA);
`else
        chk("t6_fg", 32'(cap[4]), 32'h FFFFFF);
        chk("t6_bg_int", 32'(cap[5]), 32'h5555FF);
`endif

        for (int l = 0; l < 30; l++) begin
            int y, off, xb, ds, rst_at;
            y      = int'($urandom_range(0, 479));
            off    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 255)) : int'($urandom_range(0, 29));
            xb     = (l % 3 == 0) ? 544 : 0;
            ds     = (l == 5) ? 3 : 0;
            rst_at = ($urandom_range(0, 7) == 0) ? xb + int'($urandom_range(10, 90)) : -1;
            for (int x = xb; x < xb + 128; x++) begin
                if (x == rst_at) do_reset();
                step(x, y, x >= xb + ds && x < xb + 96, x >= xb + 104 && x < xb + 112, 0, off);
            end
            if (l % 4 == 3) begin
                for (int k = 0; k < 12; k++) step(700, 500, 0, 0, k < 3, off);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
